demux1_2_2bit_fifo: RTL

Buffered 1:2 demultiplexer for 2-bit words, the receiving-side counterpart of the 2-bit 2:1 mux stage. Each accepted input word is routed by `selec_2bit` into one of two independent FIFOs. Each FIFO presents its head word on its own output with a valid/pop handshake. It sits downstream of a mux stage and splits a shared 2-bit lane back into two consumer lanes.

---
 rtl/demux1_2_2bit_fifo_if.sv | 28 ++
 rtl/demux1_2_2bit_fifo.sv | 78 +++++++
 2 files changed

// File: rtl/demux1_2_2bit_fifo_if.sv
// Handshake bundle for the buffered 1:2 demux: one producer lane in, two consumer lanes out.
interface demux1_2_2bit_fifo_if;
   logic [1:0] in_demux2bit;
   logic       valid_in;
   logic       selec_2bit;
   logic       ready_in;
   logic [1:0] out1_demux2bit;
   logic       valid_out1;
   logic       pop1;
   logic [1:0] out2_demux2bit;
   logic       valid_out2;
   logic       pop2;
   logic       full1;
   logic       full2;
   logic       err;

   modport master (
      output in_demux2bit, valid_in, selec_2bit, pop1, pop2,
      input  ready_in, out1_demux2bit, valid_out1, out2_demux2bit, valid_out2,
             full1, full2, err
   );

   modport slave (
      input  in_demux2bit, valid_in, selec_2bit, pop1, pop2,
      output ready_in, out1_demux2bit, valid_out1, out2_demux2bit, valid_out2,
             full1, full2, err
   );
endinterface

// File: rtl/demux1_2_2bit_fifo.sv
// Buffered 1:2 demux: each accepted 2-bit word goes to one of two independent
// first-word-fall-through FIFOs chosen by selec_2bit.
module demux1_2_2bit_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input logic                  clk,
   input logic                  reset_L,
   demux1_2_2bit_fifo_if.slave  bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [1:0] push;
   logic [1:0] pop_req;
   logic [1:0] pop;
   logic [1:0] full;
   logic [1:0] valid;
   logic [1:0] head [2];
   logic       err_q;

   // No full-bypass: readiness depends only on the selected FIFO's fill level.
   assign bus.ready_in = bus.selec_2bit ? !full[1] : !full[0];
   assign push[0]      = bus.valid_in & bus.ready_in & ~bus.selec_2bit;
   assign push[1]      = bus.valid_in & bus.ready_in &  bus.selec_2bit;
   assign pop_req      = {bus.pop2, bus.pop1};
   assign pop          = pop_req & valid;

   for (genvar f = 0; f < 2; f++) begin : g_fifo
      logic [1:0]    mem [DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [CW-1:0] count;
      logic [1:0]    last_q;

      // Storage carries no reset; contents are unreachable until rewritten.
      always_ff @(posedge clk) begin
         if (push[f]) mem[wr_ptr] <= bus.in_demux2bit;
      end

      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= 2'b00;
         end else begin
            if (push[f]) wr_ptr <= wr_ptr + PW'(1);
            if (pop[f])  rd_ptr <= rd_ptr + PW'(1);
            if (push[f] && !pop[f])      count <= count + CW'(1);
            else if (!push[f] && pop[f]) count <= count - CW'(1);
            // Remember the current head so the output holds it once the FIFO drains.
            if (valid[f]) last_q <= mem[rd_ptr];
         end
      end

      assign full[f]  = (count == CW'(DEPTH));
      assign valid[f] = (count != '0);
      assign head[f]  = valid[f] ? mem[rd_ptr] : last_q;
   end

   // Sticky error: pop from an empty FIFO or a rejected push.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         err_q <= 1'b0;
      end else if ((bus.pop1 & ~valid[0]) | (bus.pop2 & ~valid[1]) |
                   (bus.valid_in & ~bus.ready_in)) begin
         err_q <= 1'b1;
      end
   end

   assign bus.out1_demux2bit = head[0];
   assign bus.out2_demux2bit = head[1];
   assign bus.valid_out1     = valid[0];
   assign bus.valid_out2     = valid[1];
   assign bus.full1          = full[0];
   assign bus.full2          = full[1];
   assign bus.err            = err_q;
endmodule
